// File: rtl/pin_scan_pkg.sv
// rtl/pin_scan_pkg.sv - shared states, field widths, timing units and ASCII helpers for the pin scan sequencer
package pin_scan_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ANNOUNCE,
    ST_LETTER_ON,
    ST_LETTER_OFF,
    ST_GAP,
    ST_NUMBER_ON,
    ST_NUMBER_OFF,
    ST_TRAIL,
    ST_NEXT
  } state_e;

  localparam int LETTER_W    = 5;
  localparam int NUMBER_W    = 5;
  localparam int ENTRY_W     = LETTER_W + NUMBER_W;
  localparam int UNIT_W      = 3;
  localparam int GAP_UNITS   = 2;
  localparam int TRAIL_UNITS = 6;

  localparam logic [7:0] ASCII_A_BASE = 8'h40;
  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

  typedef struct packed {
    state_e                state;
    logic [LETTER_W-1:0]   reps;
    logic [UNIT_W-1:0]     units;
  } phase_t;

  // First pulse phase of a pin: letters, else straight to the gap, else skip the pin.
  function automatic phase_t first_phase(input logic [ENTRY_W-1:0] id);
    phase_t p;
    p.state = ST_NEXT;
    p.reps  = '0;
    p.units = '0;
    if (id[ENTRY_W-1:NUMBER_W] != '0) begin
      p.state = ST_LETTER_ON;
      p.reps  = id[ENTRY_W-1:NUMBER_W];
      p.units = UNIT_W'(1);
    end else if (id[NUMBER_W-1:0] != '0) begin
      p.state = ST_GAP;
      p.units = UNIT_W'(GAP_UNITS);
    end
    return p;
  endfunction

  function automatic logic [7:0] announce_byte(input logic [ENTRY_W-1:0] id, input logic [1:0] k);
    logic [7:0]          b;
    logic [NUMBER_W-1:0] n;
    n = id[NUMBER_W-1:0];
    case (k)
      2'd0:    b = ASCII_A_BASE + 8'(id[ENTRY_W-1:NUMBER_W]);
      2'd1:    b = ASCII_0 + 8'(n / NUMBER_W'(10));
      2'd2:    b = ASCII_0 + 8'(n % NUMBER_W'(10));
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pin_scan_prescaler.sv
// rtl/pin_scan_prescaler.sv - code-unit tick generator; clear_i holds the count at zero
module pin_scan_prescaler #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pin_scan_sequencer.sv
// rtl/pin_scan_sequencer.sv - drives one pin at a time with letter/number pulse codes
// PIN_SCAN_UART_EN adds a per-pin ASCII ball-name announce over the tx byte handshake.
module pin_scan_sequencer
  import pin_scan_pkg::*;
#(
  parameter int               NPINS           = 16,
  parameter int               TICK_DIV        = 2500000,
  parameter logic [NPINS-1:0] ACTIVE_LOW_MASK = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       hold_i,
  input  logic [NPINS*ENTRY_W-1:0]   pin_id_i,
  output logic [NPINS-1:0]           pins_o,
  output logic [$clog2(NPINS)-1:0]   active_idx_o,
  output logic                       scan_done_o
`ifdef PIN_SCAN_UART_EN
  ,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i
`endif
);

  localparam int IW = $clog2(NPINS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPINS - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [ENTRY_W-1:0]   id_q, id_d, entry_id;
  logic [LETTER_W-1:0]  rep_q, rep_d;
  logic [UNIT_W-1:0]    unit_q, unit_d;
  logic [NPINS-1:0]     pins_q, pins_d;
  logic                 done_q, done_d;
  logic                 drive, tick, clr, start, last_unit;
  phase_t               ph;
  logic [ENTRY_W-1:0]   ids [NPINS];

`ifdef PIN_SCAN_UART_EN
  logic [1:0]           byte_q, byte_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
`endif

  for (genvar g = 0; g < NPINS; g++) begin : g_ids
    assign ids[g] = pin_id_i[g*ENTRY_W +: ENTRY_W];
  end

  // Clearing in NEXT keeps every pin's first unit a full TICK_DIV long.
  assign clr = (state_q == ST_IDLE) || (state_q == ST_ANNOUNCE) || (state_q == ST_NEXT);

  pin_scan_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clr),
    .tick_o  (tick)
  );

  assign last_unit = tick && (unit_q == UNIT_W'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    id_d     = id_q;
    rep_d    = rep_q;
    unit_d   = unit_q;
    done_d   = 1'b0;
    drive    = 1'b0;
    start    = 1'b0;
    entry_id = '0;
    ph       = first_phase(id_q);
`ifdef PIN_SCAN_UART_EN
    byte_d     = byte_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
`endif
    if (tick) unit_d = unit_q - UNIT_W'(1);

    case (state_q)
      ST_IDLE: start = enable_i;
`ifdef PIN_SCAN_UART_EN
      ST_ANNOUNCE: begin
        if (tx_valid_q && tx_ready_i) begin
          if (byte_q == 2'd3) begin
            tx_valid_d = 1'b0;
            state_d    = ph.state;
            rep_d      = ph.reps;
            unit_d     = ph.units;
          end else begin
            byte_d    = byte_q + 2'd1;
            tx_data_d = announce_byte(id_q, byte_q + 2'd1);
          end
        end
      end
`endif
      ST_LETTER_ON: begin
        drive = 1'b1;
        if (last_unit) begin
          state_d = ST_LETTER_OFF;
          unit_d  = UNIT_W'(1);
        end
      end
      ST_LETTER_OFF: begin
        if (last_unit) begin
          if (rep_q > LETTER_W'(1)) begin
            state_d = ST_LETTER_ON;
            rep_d   = rep_q - LETTER_W'(1);
            unit_d  = UNIT_W'(1);
          end else begin
            state_d = ST_GAP;
            unit_d  = UNIT_W'(GAP_UNITS);
          end
        end
      end
      ST_GAP: begin
        if (last_unit) begin
          if (id_q[NUMBER_W-1:0] != '0) begin
            state_d = ST_NUMBER_ON;
            rep_d   = id_q[NUMBER_W-1:0];
            unit_d  = UNIT_W'(1);
          end else begin
            state_d = ST_TRAIL;
            unit_d  = UNIT_W'(TRAIL_UNITS);
          end
        end
      end
      ST_NUMBER_ON: begin
        drive = 1'b1;
        if (last_unit) begin
          state_d = ST_NUMBER_OFF;
          unit_d  = UNIT_W'(1);
        end
      end
      ST_NUMBER_OFF: begin
        if (last_unit) begin
          if (rep_q > LETTER_W'(1)) begin
            state_d = ST_NUMBER_ON;
            rep_d   = rep_q - LETTER_W'(1);
            unit_d  = UNIT_W'(1);
          end else begin
            state_d = ST_TRAIL;
            unit_d  = UNIT_W'(TRAIL_UNITS);
          end
        end
      end
      ST_TRAIL: begin
        if (last_unit) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        start = 1'b1;
        if (!hold_i) begin
          idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
          done_d = (idx_q == LAST_IDX);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The pin's ID is captured here and held for its whole code.
    if (start) begin
      entry_id = ids[idx_d];
      id_d     = entry_id;
      ph       = first_phase(entry_id);
`ifdef PIN_SCAN_UART_EN
      if (entry_id != '0) begin
        state_d    = ST_ANNOUNCE;
        byte_d     = 2'd0;
        tx_valid_d = 1'b1;
        tx_data_d  = announce_byte(entry_id, 2'd0);
      end else begin
        state_d = ph.state;
        rep_d   = ph.reps;
        unit_d  = ph.units;
      end
`else
      state_d = ph.state;
      rep_d   = ph.reps;
      unit_d  = ph.units;
`endif
    end

    if (!enable_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
      drive   = 1'b0;
`ifdef PIN_SCAN_UART_EN
      tx_valid_d = 1'b0;
`endif
    end
  end

  always_comb begin
    pins_d = ACTIVE_LOW_MASK;
    if (drive) pins_d[idx_q] = ~ACTIVE_LOW_MASK[idx_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      id_q    <= '0;
      rep_q   <= '0;
      unit_q  <= '0;
      pins_q  <= ACTIVE_LOW_MASK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      rep_q   <= rep_d;
      unit_q  <= unit_d;
      pins_q  <= pins_d;
      done_q  <= done_d;
    end
  end

`ifdef PIN_SCAN_UART_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_q     <= 2'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      byte_q     <= byte_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
`endif

  assign pins_o       = pins_q;
  assign active_idx_o = idx_q;
  assign scan_done_o  = done_q;

endmodule

// File: tb/tb_pin_scan_sequencer.sv
// tb/tb_pin_scan_sequencer.sv - directed and randomized checks of pin_scan_sequencer against a unit-level timing model
`timescale 1ns/1ps
module tb_pin_scan_sequencer;
  localparam int NP = 4;
  localparam int TD = 4;
  localparam logic [NP-1:0] MASK = 4'b1000;
`ifdef PIN_SCAN_UART_EN
  localparam int ANN = 4;
`else
  localparam int ANN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            hold = 1'b0;
  logic [NP*10-1:0] pin_id = '0;
  logic [NP-1:0]   pins;
  logic [1:0]      idx;
  logic            done;
`ifdef PIN_SCAN_UART_EN
  logic [7:0]      txd;
  logic            txv;
  logic            txr = 1'b1;
`endif

  pin_scan_sequencer #(.NPINS(NP), .TICK_DIV(TD), .ACTIVE_LOW_MASK(MASK)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (en),
    .hold_i       (hold),
    .pin_id_i     (pin_id),
    .pins_o       (pins),
    .active_idx_o (idx),
    .scan_done_o  (done)
`ifdef PIN_SCAN_UART_EN
    ,
    .tx_data_o    (txd),
    .tx_valid_o   (txv),
    .tx_ready_i   (txr)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int lt [NP];
  int nm [NP];
  bit hold_plan [$];
  int cyc, done_seen, fall_letter, fall_number, idx_c88, idx_c89;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load_ids();
    for (int i = 0; i < NP; i++) pin_id[10*i +: 10] = {lt[i][4:0], nm[i][4:0]};
  endtask

  // Expected drive o cycles after the pulse phase begins (pin outputs lag the state by one cycle).
  function automatic bit pulse_on(input int L, input int N, input int o);
    int u;
    if (o < 1) return 1'b0;
    u = (o - 1) / TD;
    if (u < 2*L) return (u % 2) == 0;
    u = u - 2*L - 2;
    if (u >= 0 && u < 2*N) return (u % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic [7:0] ann_byte(input int L, input int N, input int k);
    case (k)
      0: return 8'(64 + L);
      1: return 8'(48 + N / 10);
      2: return 8'(48 + N % 10);
      default: return 8'h0A;
    endcase
  endfunction

  // Caller raises en at a negedge with the DUT idle; each visit is one pin code plus its NEXT cycle.
  task automatic run_scan(input int nvis);
    int p;
    bit wrap;
    p = 0;
    wrap = 1'b0;
    for (int v = 0; v < nvis; v++) begin
      int L, N, pre, D;
      bit skip, h, on, prev3;
      logic [NP-1:0] ep;
      L = lt[p];
      N = nm[p];
      skip = (L == 0 && N == 0);
      pre = skip ? 0 : ANN;
      D = skip ? 1 : pre + (2*L + 2 + 2*N + 6) * TD + 1;
      h = (hold_plan.size() > 0) ? hold_plan.pop_front() : 1'b0;
      prev3 = MASK[3];
      for (int o = 0; o < D; o++) begin
        @(negedge clk);
        if (o == 0) hold = h;
        on = !skip && pulse_on(L, N, o - pre);
        ep = MASK ^ (on ? NP'(1 << p) : NP'(0));
        chk("pins", pins, ep);
        chk("idx", idx, p);
        chk("scan_done", done, (o == 0 && wrap));
        chk("one_active", ($countones(pins ^ MASK) <= 1), 1);
`ifdef PIN_SCAN_UART_EN
        chk("tx_valid", txv, (o < pre));
        if (o < pre) chk("tx_data", txd, ann_byte(L, N, o));
`endif
        if (p == 3) begin
          if (prev3 == 1'b1 && pins[3] == 1'b0) begin
            if (o - pre <= 2*L*TD) fall_letter++;
            else fall_number++;
          end
          prev3 = pins[3];
        end
        if (cyc == 88 + ANN) idx_c88 = idx;
        if (cyc == 89 + ANN) idx_c89 = idx;
        done_seen += done;
        cyc++;
      end
      wrap = !h && (p == NP-1);
      if (!h) p = (p + 1) % NP;
    end
  endtask

  initial begin
    lt = '{3, 4, 6, 20};
    nm = '{4, 3, 5, 6};
    load_ids();
    repeat (3) @(negedge clk);
    chk("reset_pins", pins, MASK);
    chk("reset_idx", idx, 0);
    chk("reset_done", done, 0);
`ifdef PIN_SCAN_UART_EN
    chk("reset_tx_valid", txv, 0);
    chk("reset_tx_data", txd, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_pins", pins, MASK);

    // Full scan of C4 D3 F5 T6 plus the first cycle of the wrap back to pin 0.
    cyc = 0; done_seen = 0; fall_letter = 0; fall_number = 0; idx_c88 = -1; idx_c89 = -1;
    en = 1'b1;
    run_scan(5);
    chk("scan_done_count", done_seen, 1);
    chk("idx_at_88", idx_c88, 0);
    chk("idx_at_89", idx_c89, 1);
    chk("pin3_letter_pulses", fall_letter, 20);
    chk("pin3_number_pulses", fall_number, 6);
    en = 1'b0;
    @(negedge clk);
    chk("disable_pins", pins, MASK);
    chk("disable_idx", idx, 0);

    // Skipped pin 1 and a held pin 2.
    lt = '{2, 0, 1, 3};
    nm = '{1, 0, 2, 1};
    load_ids();
    hold_plan = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    en = 1'b1;
    run_scan(5);
    en = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("skip_end_idx", idx, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NP; i++) begin
        lt[i] = $urandom_range(0, 3);
        nm[i] = $urandom_range(0, 3);
      end
      load_ids();
      hold_plan.delete();
      for (int v = 0; v < 6; v++) hold_plan.push_back($urandom_range(0, 3) == 0);
      en = 1'b1;
      run_scan(6);
      en = 1'b0;
      hold = 1'b0;
      @(negedge clk);
      chk("rand_disable_pins", pins, MASK);
      chk("rand_disable_idx", idx, 0);
    end

    // Drop enable in pin 1's first number pulse.
    lt = '{3, 4, 6, 20};
    nm = '{4, 3, 5, 6};
    load_ids();
    en = 1'b1;
    repeat (131 + 2*ANN) @(negedge clk);
    chk("pre_drop_pins", pins, MASK ^ 4'b0010);
    chk("pre_drop_idx", idx, 1);
    en = 1'b0;
    @(negedge clk);
    chk("drop_pins", pins, MASK);
    chk("drop_idx", idx, 0);
    chk("drop_done", done, 0);

    // Asynchronous reset in pin 1's gap.
    @(negedge clk);
    en = 1'b1;
    repeat (124 + 2*ANN) @(negedge clk);
    chk("pre_reset_idx", idx, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pins", pins, MASK);
    chk("async_reset_idx", idx, 0);
`ifdef PIN_SCAN_UART_EN
    chk("async_reset_tx_valid", txv, 0);
`endif
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_pins", pins, MASK);

`ifdef PIN_SCAN_UART_EN
    // Announce F5 with the sink stalling three cycles per byte.
    lt = '{6, 4, 6, 20};
    nm = '{5, 3, 5, 6};
    load_ids();
    txr = 1'b0;
    en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      int w;
      w = 0;
      while (txv !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("tx_valid_seen", txv, 1);
      for (int s = 0; s < 3; s++) begin
        chk("stall_data", txd, ann_byte(6, 5, b));
        chk("stall_valid", txv, 1);
        chk("stall_pins", pins, MASK);
        @(negedge clk);
      end
      chk("accept_data", txd, ann_byte(6, 5, b));
      txr = 1'b1;
      @(negedge clk);
      txr = 1'b0;
    end
    chk("after_lf_valid", txv, 0);
    chk("after_lf_pins", pins, MASK);
    @(negedge clk);
    chk("first_pulse", pins, MASK ^ 4'b0001);
    en = 1'b0;
    txr = 1'b1;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
